// File: rtl/scv_cart_if.sv
// CPU cart-window bus plus backing-memory request/acknowledge port, bundled for the cart responder.
interface scv_cart_if #(
  parameter int ROM_AW = 15
);
  logic [15:0]       A;
  logic [7:0]        DB_I;
  logic [7:0]        DB_O;
  logic              DB_OE;
  logic              RDB;
  logic              WRB;
  logic              nCS;
  logic [1:0]        BANK;
  logic              MEM_REQ;
  logic [ROM_AW-1:0] MEM_ADDR;
  logic              MEM_RAM;
  logic              MEM_WE;
  logic [7:0]        MEM_DO;
  logic [7:0]        MEM_DI;
  logic              MEM_ACK;

  modport slave (
    input  A, DB_I, RDB, WRB, nCS, BANK, MEM_DI, MEM_ACK,
    output DB_O, DB_OE, MEM_REQ, MEM_ADDR, MEM_RAM, MEM_WE, MEM_DO
  );

  modport master (
    output A, DB_I, RDB, WRB, nCS, BANK, MEM_DI, MEM_ACK,
    input  DB_O, DB_OE, MEM_REQ, MEM_ADDR, MEM_RAM, MEM_WE, MEM_DO
  );
endinterface

// File: rtl/scv_cart.sv
// Cart-window responder: turns each CPU strobe into one backing-memory req/ack transaction.
// MEM_REQ rises 1 CLK after start, read data lands on the ACK edge; a silent memory is abandoned after TIMEOUT CLKs.
module scv_cart #(
  parameter int ROM_AW  = 15,
  parameter int RAM_EN  = 0,
  parameter int TIMEOUT = 20
) (
  input  logic      CLK,
  input  logic      RESB,
  scv_cart_if.slave bus,
  output logic      ERR
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t            state_q,   state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q,  mem_we_d;
  logic              mem_ram_q, mem_ram_d;
  logic [ROM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_do_q,  mem_do_d;
  logic [7:0]        db_o_q,    db_o_d;
  logic [CW-1:0]     cnt_q,     cnt_d;
  logic              err_q,     err_d;

  logic              ram_hit;
  logic              rd_start;
  logic              wr_start;
  logic              access_end;
  logic [ROM_AW-1:0] dec_addr;

  // ROM addresses wider than the image simply wrap (mirror) through truncation.
  assign ram_hit    = (RAM_EN != 0) && (bus.A[15:13] == 3'b111);
  assign dec_addr   = ram_hit ? ROM_AW'(bus.A[12:0]) : ROM_AW'({bus.BANK, bus.A[14:0]});
  assign rd_start   = ~bus.nCS & ~bus.RDB;
  assign wr_start   = ~bus.nCS & ~bus.WRB;
  assign access_end = bus.nCS | (bus.RDB & bus.WRB);

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_ram_d  = mem_ram_q;
    mem_addr_d = mem_addr_q;
    mem_do_d   = mem_do_q;
    db_o_d     = db_o_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rd_start) begin
          db_o_d     = 8'hFF;
          mem_addr_d = dec_addr;
          mem_ram_d  = ram_hit;
          mem_we_d   = 1'b0;
          mem_req_d  = 1'b1;
          cnt_d      = '0;
          state_d    = S_WAIT;
        end else if (wr_start) begin
          if (ram_hit) begin
            mem_addr_d = dec_addr;
            mem_do_d   = bus.DB_I;
            mem_we_d   = 1'b1;
            mem_ram_d  = 1'b1;
            mem_req_d  = 1'b1;
            cnt_d      = '0;
            state_d    = S_WAIT;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_WAIT: begin
        if (bus.MEM_ACK) begin
          mem_req_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_HOLD;
          if (!mem_we_q) begin
            db_o_d = bus.MEM_DI;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          cnt_d     = '0;
          state_d   = S_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        // Waiting for the strobe to drop is what stops a held strobe from retriggering.
        if (access_end) begin
          mem_we_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_ram_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_do_q   <= 8'h00;
      db_o_q     <= 8'hFF;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_ram_q  <= mem_ram_d;
      mem_addr_q <= mem_addr_d;
      mem_do_q   <= mem_do_d;
      db_o_q     <= db_o_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign bus.MEM_REQ  = mem_req_q;
  assign bus.MEM_WE   = mem_we_q;
  assign bus.MEM_RAM  = mem_ram_q;
  assign bus.MEM_ADDR = mem_addr_q;
  assign bus.MEM_DO   = mem_do_q;
  assign bus.DB_O     = db_o_q;
  assign bus.DB_OE    = ~(bus.nCS | bus.RDB);
  assign ERR          = err_q;

endmodule

// File: tb/tb_scv_cart.sv
// Two carts share one CPU bus: dut0 is a 32 KB ROM-only cart, dut1 a 128 KB cart with SRAM.
module tb_scv_cart;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [15:0] a;
  logic [7:0]  db_i;
  logic        rdb, wrb, ncs;
  logic [1:0]  bank;
  logic [1:0]  ack_r = 2'b00;
  logic [1:0]  spur_ack;
  logic [7:0]  spur_dat [2];
  logic [7:0]  di_r [2] = '{8'h00, 8'h00};
  logic        err0, err1;

  scv_cart_if #(.ROM_AW(15)) if0 ();
  scv_cart_if #(.ROM_AW(17)) if1 ();

  assign if0.A = a;      assign if1.A = a;
  assign if0.DB_I = db_i; assign if1.DB_I = db_i;
  assign if0.RDB = rdb;  assign if1.RDB = rdb;
  assign if0.WRB = wrb;  assign if1.WRB = wrb;
  assign if0.nCS = ncs;  assign if1.nCS = ncs;
  assign if0.BANK = bank; assign if1.BANK = bank;
  assign if0.MEM_ACK = ack_r[0] | spur_ack[0];
  assign if1.MEM_ACK = ack_r[1] | spur_ack[1];
  assign if0.MEM_DI = spur_ack[0] ? spur_dat[0] : di_r[0];
  assign if1.MEM_DI = spur_ack[1] ? spur_dat[1] : di_r[1];

  scv_cart #(.ROM_AW(15), .RAM_EN(0), .TIMEOUT(20)) dut0 (.CLK(clk), .RESB(rst_n), .bus(if0), .ERR(err0));
  scv_cart #(.ROM_AW(17), .RAM_EN(1), .TIMEOUT(20)) dut1 (.CLK(clk), .RESB(rst_n), .bus(if1), .ERR(err1));

  logic [1:0]  m_req, m_we, m_ram, m_oe, errv;
  logic [16:0] m_addr [2];
  logic [7:0]  m_do [2];
  logic [7:0]  m_dbo [2];
  assign m_req = {if1.MEM_REQ, if0.MEM_REQ};
  assign m_we  = {if1.MEM_WE, if0.MEM_WE};
  assign m_ram = {if1.MEM_RAM, if0.MEM_RAM};
  assign m_oe  = {if1.DB_OE, if0.DB_OE};
  assign errv  = {err1, err0};
  assign m_addr[0] = {2'b00, if0.MEM_ADDR};
  assign m_addr[1] = if1.MEM_ADDR;
  assign m_do[0] = if0.MEM_DO;  assign m_do[1] = if1.MEM_DO;
  assign m_dbo[0] = if0.DB_O;   assign m_dbo[1] = if1.DB_O;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Backing-memory responder state; dly==0 means never acknowledge.
  int          dly [2] = '{3, 3};
  int          force_di = -1;
  int          rcnt [2] = '{0, 0};
  int          txn [2] = '{0, 0};
  int          req_hi [2] = '{0, 0};
  int          errs [2] = '{0, 0};
  int          rise_cyc [2] = '{0, 0};
  logic [16:0] l_addr [2];
  logic        l_ram [2];
  logic        l_we [2];
  logic [7:0]  l_do [2];
  logic [7:0]  db_after_ack [2];
  logic        prev_req [2] = '{1'b0, 1'b0};
  logic        mem_done = 1'b0;
  logic [7:0]  mem_ram [2][8192];
  logic [7:0]  exp_ram [2][8192];

  function automatic logic [7:0] rom_dat(input logic [16:0] ad);
    return ad[7:0] ^ ad[15:8] ^ {7'b0, ad[16]} ^ 8'hC3;
  endfunction

  always @(negedge clk) begin
    if (!mem_done) begin
      for (int j = 0; j < 8192; j++) begin
        mem_ram[0][j] <= 8'(j * 3);
        mem_ram[1][j] <= 8'(j * 3);
      end
      mem_done <= 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      prev_req[i] <= m_req[i];
      if (!rst_n) begin
        ack_r[i] <= 1'b0;
        rcnt[i]  <= 0;
      end else if (ack_r[i]) begin
        ack_r[i]        <= 1'b0;
        rcnt[i]         <= 0;
        db_after_ack[i] <= m_dbo[i];
      end else if (m_req[i]) begin
        if (!prev_req[i]) begin
          txn[i]      <= txn[i] + 1;
          l_addr[i]   <= m_addr[i];
          l_ram[i]    <= m_ram[i];
          l_we[i]     <= m_we[i];
          l_do[i]     <= m_do[i];
          rise_cyc[i] <= cyc;
          req_hi[i]   <= 1;
        end else begin
          req_hi[i] <= req_hi[i] + 1;
        end
        rcnt[i] <= (prev_req[i] ? rcnt[i] : 0) + 1;
        if (dly[i] > 0 && (prev_req[i] ? rcnt[i] : 0) + 1 == dly[i]) begin
          ack_r[i] <= 1'b1;
          if (m_we[i])
            mem_ram[i][m_addr[i][12:0]] <= m_do[i];
          else if (force_di >= 0)
            di_r[i] <= force_di[7:0];
          else
            di_r[i] <= m_ram[i] ? mem_ram[i][m_addr[i][12:0]] : rom_dat(m_addr[i]);
        end
      end
      if (rst_n && errv[i]) errs[i] <= errs[i] + 1;
    end
  end

  // Reference decode: cart i is (ROM_AW, RAM_EN) = (15,0) or (17,1).
  function automatic void model(input int i, input logic [15:0] ad, input logic [1:0] bk,
                                output logic ram, output logic [16:0] ma);
    int aw;
    int full;
    aw  = (i == 0) ? 15 : 17;
    ram = (i == 1) && (ad >= 16'hE000);
    if (ram) begin
      ma = 17'(int'(ad) % 8192);
    end else begin
      full = int'(bk) * 32768 + int'(ad) % 32768;
      ma   = 17'(full % (1 << aw));
    end
  endfunction

  function automatic logic [7:0] exp_rd(input int i, input logic ram, input logic [16:0] ma);
    return ram ? exp_ram[i][ma[12:0]] : rom_dat(ma);
  endfunction

  task automatic cpu_op(input bit rd, input logic [15:0] ad, input logic [1:0] bk, input logic [7:0] wd,
                        input int hold, input int post, output int ts);
    @(negedge clk);
    a = ad; bank = bk; db_i = wd; ncs = 1'b0;
    rdb = rd ? 1'b0 : 1'b1;
    wrb = rd ? 1'b1 : 1'b0;
    ts = cyc;
    repeat (hold) @(negedge clk);
    rdb = 1'b1; wrb = 1'b1; ncs = 1'b1;
    repeat (post) @(negedge clk);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      total++; if (m_req[i] !== 1'b0) begin bad++; $display("FAIL reset_req dut%0d got=%b want=0", i, m_req[i]); end
      total++; if (m_we[i] !== 1'b0) begin bad++; $display("FAIL reset_we dut%0d got=%b want=0", i, m_we[i]); end
      total++; if (m_ram[i] !== 1'b0) begin bad++; $display("FAIL reset_ram dut%0d got=%b want=0", i, m_ram[i]); end
      total++; if (m_addr[i] !== 17'h0) begin bad++; $display("FAIL reset_addr dut%0d got=%h want=0", i, m_addr[i]); end
      total++; if (m_do[i] !== 8'h00) begin bad++; $display("FAIL reset_do dut%0d got=%h want=00", i, m_do[i]); end
      total++; if (m_dbo[i] !== 8'hFF) begin bad++; $display("FAIL reset_dbo dut%0d got=%h want=ff", i, m_dbo[i]); end
      total++; if (errv[i] !== 1'b0) begin bad++; $display("FAIL reset_err dut%0d got=%b want=0", i, errv[i]); end
      total++; if (m_oe[i] !== 1'b0) begin bad++; $display("FAIL reset_oe dut%0d got=%b want=0", i, m_oe[i]); end
    end
  endtask

  task automatic test_read_hit;
    int ts;
    int t0 [2];
    dly = '{3, 3}; force_di = 8'h5A; t0 = txn;
    @(negedge clk);
    a = 16'h8123; bank = 2'b00; ncs = 1'b0; rdb = 1'b0; wrb = 1'b1; ts = cyc;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      total++; if (m_req[i] !== 1'b1) begin bad++; $display("FAIL hit_req_rise dut%0d got=%b want=1", i, m_req[i]); end
      total++; if (m_oe[i] !== 1'b1) begin bad++; $display("FAIL hit_oe dut%0d got=%b want=1", i, m_oe[i]); end
    end
    repeat (29) @(negedge clk);
    rdb = 1'b1; ncs = 1'b1;
    repeat (3) @(negedge clk);
    force_di = -1;
    for (int i = 0; i < 2; i++) begin
      total++; if (txn[i] - t0[i] !== 1) begin bad++; $display("FAIL hit_txn dut%0d got=%0d want=1", i, txn[i] - t0[i]); end
      total++; if (l_addr[i] !== 17'h00123) begin bad++; $display("FAIL hit_addr dut%0d got=%h want=00123", i, l_addr[i]); end
      total++; if (l_ram[i] !== 1'b0 || l_we[i] !== 1'b0) begin bad++; $display("FAIL hit_ram_we dut%0d got=%b%b want=00", i, l_ram[i], l_we[i]); end
      total++; if (rise_cyc[i] !== ts + 1) begin bad++; $display("FAIL hit_latency dut%0d got=%0d want=%0d", i, rise_cyc[i], ts + 1); end
      total++; if (req_hi[i] !== 3) begin bad++; $display("FAIL hit_req_len dut%0d got=%0d want=3", i, req_hi[i]); end
      total++; if (db_after_ack[i] !== 8'h5A) begin bad++; $display("FAIL hit_ack_edge dut%0d got=%h want=5a", i, db_after_ack[i]); end
      total++; if (m_dbo[i] !== 8'h5A) begin bad++; $display("FAIL hit_dbo dut%0d got=%h want=5a", i, m_dbo[i]); end
      total++; if (m_oe[i] !== 1'b0) begin bad++; $display("FAIL hit_oe_off dut%0d got=%b want=0", i, m_oe[i]); end
    end
  endtask

  task automatic test_banking;
    int ts;
    logic ram;
    logic [16:0] ma;
    logic [15:0] ad;
    logic [1:0] bk;
    dly = '{2, 2};
    cpu_op(1'b1, 16'hC000, 2'b10, 8'h00, 30, 3, ts);
    total++; if (l_addr[1] !== 17'h14000) begin bad++; $display("FAIL bank_wide got=%h want=14000", l_addr[1]); end
    total++; if (l_addr[0] !== 17'h04000) begin bad++; $display("FAIL bank_mirror got=%h want=04000", l_addr[0]); end
    for (int k = 0; k < 6; k++) begin
      ad = 16'(32'h8000 + $urandom_range(0, 32'h5FFF));
      bk = 2'($urandom_range(0, 3));
      cpu_op(1'b1, ad, bk, 8'h00, 30, 3, ts);
      for (int i = 0; i < 2; i++) begin
        model(i, ad, bk, ram, ma);
        total++; if (l_addr[i] !== ma) begin bad++; $display("FAIL bank_addr dut%0d a=%h bank=%0d got=%h want=%h", i, ad, bk, l_addr[i], ma); end
        total++; if (m_dbo[i] !== exp_rd(i, ram, ma)) begin bad++; $display("FAIL bank_data dut%0d got=%h want=%h", i, m_dbo[i], exp_rd(i, ram, ma)); end
      end
    end
  endtask

  task automatic test_ram_write;
    int ts;
    int t0 [2];
    logic ram;
    logic [16:0] ma;
    dly = '{3, 3}; t0 = txn;
    cpu_op(1'b0, 16'hE010, 2'b00, 8'hA5, 30, 3, ts);
    total++; if (txn[1] - t0[1] !== 1) begin bad++; $display("FAIL ramwr_txn got=%0d want=1", txn[1] - t0[1]); end
    total++; if (l_we[1] !== 1'b1 || l_ram[1] !== 1'b1) begin bad++; $display("FAIL ramwr_we_ram got=%b%b want=11", l_we[1], l_ram[1]); end
    total++; if (l_addr[1] !== 17'h00010) begin bad++; $display("FAIL ramwr_addr got=%h want=00010", l_addr[1]); end
    total++; if (l_do[1] !== 8'hA5) begin bad++; $display("FAIL ramwr_do got=%h want=a5", l_do[1]); end
    total++; if (m_we[1] !== 1'b0) begin bad++; $display("FAIL ramwr_we_clear got=%b want=0", m_we[1]); end
    total++; if (txn[0] - t0[0] !== 0) begin bad++; $display("FAIL ramwr_norom_txn got=%0d want=0", txn[0] - t0[0]); end
    exp_ram[1][13'h0010] = 8'hA5;
    cpu_op(1'b1, 16'hE010, 2'b00, 8'h00, 30, 3, ts);
    total++; if (m_dbo[1] !== 8'hA5) begin bad++; $display("FAIL ramrd_data got=%h want=a5", m_dbo[1]); end
    total++; if (l_ram[1] !== 1'b1) begin bad++; $display("FAIL ramrd_space got=%b want=1", l_ram[1]); end
    model(0, 16'hE010, 2'b00, ram, ma);
    total++; if (m_dbo[0] !== exp_rd(0, ram, ma)) begin bad++; $display("FAIL ramrd_rom_cart got=%h want=%h", m_dbo[0], exp_rd(0, ram, ma)); end
  endtask

  task automatic test_timeout;
    int ts;
    int t0 [2];
    int e0 [2];
    dly = '{0, 0}; t0 = txn; e0 = errs;
    cpu_op(1'b1, 16'h8001, 2'b00, 8'h00, 30, 3, ts);
    for (int i = 0; i < 2; i++) begin
      total++; if (req_hi[i] !== 20) begin bad++; $display("FAIL to_req_len dut%0d got=%0d want=20", i, req_hi[i]); end
      total++; if (errs[i] - e0[i] !== 1) begin bad++; $display("FAIL to_err dut%0d got=%0d want=1", i, errs[i] - e0[i]); end
      total++; if (m_dbo[i] !== 8'hFF) begin bad++; $display("FAIL to_dbo dut%0d got=%h want=ff", i, m_dbo[i]); end
      total++; if (txn[i] - t0[i] !== 1) begin bad++; $display("FAIL to_txn dut%0d got=%0d want=1", i, txn[i] - t0[i]); end
    end
    dly = '{3, 3};
  endtask

  task automatic test_held_strobe;
    int ts;
    int t0 [2];
    logic ram;
    logic [16:0] ma;
    dly = '{4, 4}; t0 = txn;
    cpu_op(1'b1, 16'h8456, 2'b01, 8'h00, 60, 3, ts);
    for (int i = 0; i < 2; i++) begin
      total++; if (txn[i] - t0[i] !== 1) begin bad++; $display("FAIL held_single dut%0d got=%0d want=1", i, txn[i] - t0[i]); end
    end
    cpu_op(1'b1, 16'h8457, 2'b01, 8'h00, 30, 3, ts);
    for (int i = 0; i < 2; i++) begin
      model(i, 16'h8457, 2'b01, ram, ma);
      total++; if (txn[i] - t0[i] !== 2) begin bad++; $display("FAIL held_second dut%0d got=%0d want=2", i, txn[i] - t0[i]); end
      total++; if (m_dbo[i] !== exp_rd(i, ram, ma)) begin bad++; $display("FAIL held_data dut%0d got=%h want=%h", i, m_dbo[i], exp_rd(i, ram, ma)); end
    end
  endtask

  task automatic test_early_release;
    int ts;
    int t0 [2];
    logic ram;
    logic [16:0] ma;
    dly = '{8, 8}; t0 = txn;
    cpu_op(1'b1, 16'h9ABC, 2'b11, 8'h00, 2, 15, ts);
    for (int i = 0; i < 2; i++) begin
      model(i, 16'h9ABC, 2'b11, ram, ma);
      total++; if (txn[i] - t0[i] !== 1) begin bad++; $display("FAIL early_txn dut%0d got=%0d want=1", i, txn[i] - t0[i]); end
      total++; if (m_dbo[i] !== exp_rd(i, ram, ma)) begin bad++; $display("FAIL early_data dut%0d got=%h want=%h", i, m_dbo[i], exp_rd(i, ram, ma)); end
    end
    dly = '{3, 3};
    cpu_op(1'b1, 16'h9ABD, 2'b11, 8'h00, 30, 3, ts);
    for (int i = 0; i < 2; i++) begin
      model(i, 16'h9ABD, 2'b11, ram, ma);
      total++; if (rise_cyc[i] !== ts + 1) begin bad++; $display("FAIL early_next_start dut%0d got=%0d want=%0d", i, rise_cyc[i], ts + 1); end
      total++; if (m_dbo[i] !== exp_rd(i, ram, ma)) begin bad++; $display("FAIL early_next_data dut%0d got=%h want=%h", i, m_dbo[i], exp_rd(i, ram, ma)); end
    end
  endtask

  task automatic test_spurious_ack;
    int t0 [2];
    logic [7:0] d0 [2];
    t0 = txn; d0 = m_dbo;
    spur_dat[0] = ~d0[0]; spur_dat[1] = ~d0[1];
    @(negedge clk); spur_ack = 2'b11;
    @(negedge clk); spur_ack = 2'b00;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      total++; if (m_dbo[i] !== d0[i]) begin bad++; $display("FAIL spur_dbo dut%0d got=%h want=%h", i, m_dbo[i], d0[i]); end
      total++; if (m_req[i] !== 1'b0 || txn[i] !== t0[i]) begin bad++; $display("FAIL spur_req dut%0d got=%b/%0d want=0/%0d", i, m_req[i], txn[i], t0[i]); end
    end
  endtask

  task automatic test_reset_mid;
    int ts;
    int t0 [2];
    int e0 [2];
    logic ram;
    logic [16:0] ma;
    dly = '{0, 0};
    @(negedge clk);
    a = 16'h9000; bank = 2'b00; ncs = 1'b0; rdb = 1'b0; wrb = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      total++; if (m_req[i] !== 1'b1) begin bad++; $display("FAIL rstmid_pre_req dut%0d got=%b want=1", i, m_req[i]); end
    end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      total++; if (m_req[i] !== 1'b0) begin bad++; $display("FAIL rstmid_req dut%0d got=%b want=0", i, m_req[i]); end
      total++; if (m_dbo[i] !== 8'hFF) begin bad++; $display("FAIL rstmid_dbo dut%0d got=%h want=ff", i, m_dbo[i]); end
      total++; if (m_addr[i] !== 17'h0) begin bad++; $display("FAIL rstmid_addr dut%0d got=%h want=0", i, m_addr[i]); end
    end
    @(negedge clk);
    rdb = 1'b1; ncs = 1'b1;
    #2 rst_n = 1'b1;
    dly = '{3, 3};
    repeat (2) @(negedge clk);
    t0 = txn; e0 = errs;
    cpu_op(1'b1, 16'h9001, 2'b00, 8'h00, 30, 3, ts);
    for (int i = 0; i < 2; i++) begin
      model(i, 16'h9001, 2'b00, ram, ma);
      total++; if (txn[i] - t0[i] !== 1) begin bad++; $display("FAIL rstmid_txn dut%0d got=%0d want=1", i, txn[i] - t0[i]); end
      total++; if (rise_cyc[i] !== ts + 1) begin bad++; $display("FAIL rstmid_idle dut%0d got=%0d want=%0d", i, rise_cyc[i], ts + 1); end
      total++; if (m_dbo[i] !== exp_rd(i, ram, ma)) begin bad++; $display("FAIL rstmid_data dut%0d got=%h want=%h", i, m_dbo[i], exp_rd(i, ram, ma)); end
      total++; if (errs[i] !== e0[i]) begin bad++; $display("FAIL rstmid_err dut%0d got=%0d want=%0d", i, errs[i], e0[i]); end
    end
  endtask

  task automatic test_random;
    int ts;
    int t0 [2];
    logic [7:0] d0 [2];
    logic ram;
    logic [16:0] ma;
    logic [15:0] ad;
    logic [1:0] bk;
    logic [7:0] wd;
    bit rd;
    bit hit;
    for (int k = 0; k < 30; k++) begin
      rd = 1'($urandom_range(0, 1));
      ad = 16'(32'h8000 + $urandom_range(0, 32'h7F7F));
      if (k % 4 == 0) ad = 16'(32'hE000 + $urandom_range(0, 32'h1F7F));
      bk = 2'($urandom_range(0, 3));
      wd = 8'($urandom_range(0, 255));
      dly[0] = $urandom_range(1, 10);
      dly[1] = $urandom_range(1, 10);
      t0 = txn; d0 = m_dbo;
      cpu_op(rd, ad, bk, wd, 30, 3, ts);
      for (int i = 0; i < 2; i++) begin
        model(i, ad, bk, ram, ma);
        hit = rd || ram;
        total++; if (txn[i] - t0[i] !== (hit ? 1 : 0)) begin bad++; $display("FAIL rnd_txn dut%0d rd=%0d a=%h got=%0d want=%0d", i, rd, ad, txn[i] - t0[i], hit ? 1 : 0); end
        if (hit) begin
          total++; if (l_addr[i] !== ma || l_ram[i] !== ram || l_we[i] !== !rd) begin
            bad++; $display("FAIL rnd_req dut%0d a=%h got=%h/%b/%b want=%h/%b/%b", i, ad, l_addr[i], l_ram[i], l_we[i], ma, ram, !rd);
          end
        end
        if (rd) begin
          total++; if (m_dbo[i] !== exp_rd(i, ram, ma)) begin bad++; $display("FAIL rnd_rdata dut%0d a=%h got=%h want=%h", i, ad, m_dbo[i], exp_rd(i, ram, ma)); end
        end else begin
          total++; if (m_dbo[i] !== d0[i]) begin bad++; $display("FAIL rnd_dbo_keep dut%0d got=%h want=%h", i, m_dbo[i], d0[i]); end
          if (ram) begin
            total++; if (l_do[i] !== wd) begin bad++; $display("FAIL rnd_wdata dut%0d got=%h want=%h", i, l_do[i], wd); end
            exp_ram[i][ma[12:0]] = wd;
          end
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a = 16'h0; db_i = 8'h0; rdb = 1'b1; wrb = 1'b1; ncs = 1'b1; bank = 2'b00;
    spur_ack = 2'b00; spur_dat[0] = 8'h00; spur_dat[1] = 8'h00;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 8192; j++)
        exp_ram[i][j] = 8'(j * 3);
    repeat (3) @(negedge clk);
    test_reset;
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_read_hit;
    test_banking;
    test_ram_write;
    test_timeout;
    test_held_strobe;
    test_early_release;
    test_spurious_ack;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
